// File: rtl/bus_datapath.sv
// Bus-based register-file datapath. A small FSM moves operands over one shared bus
// through an accumulator (A) and a result register (G) to run mv/mvi/add/sub/xor.
module bus_datapath #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8,
  localparam int unsigned SEL_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] instr,
  output logic              done,
  output logic              err,
  output logic              flag_z,
  output logic              flag_c,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] bus_dbg
);

  localparam int unsigned IrW = 3 + 2 * SEL_W;

  localparam logic [2:0] OpMv  = 3'b000;
  localparam logic [2:0] OpMvi = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;

  typedef enum logic [2:0] {StIdle, StImm, StT1, StT2, StT3, StDone} state_e;

  state_e              state_q, state_d;
  logic [IrW-1:0]      ir_q, ir_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [DATA_W-1:0]   a_q, a_d, g_q, g_d;
  logic                carry_q, carry_d;
  logic                fz_q, fz_d, fc_q, fc_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   bus;
  logic                wr_en;
  logic [DATA_W:0]     alu_sum;

  function automatic logic in_range(input logic [SEL_W-1:0] idx);
    return 32'(idx) < NUM_REGS;
  endfunction

  // Incoming word decode (only meaningful in IDLE)
  logic [2:0]       in_op;
  logic [SEL_W-1:0] in_rx, in_ry;
  logic             in_illegal;
  assign in_op      = instr[DATA_W-1 -: 3];
  assign in_rx      = instr[DATA_W-4 -: SEL_W];
  assign in_ry      = instr[DATA_W-4-SEL_W -: SEL_W];
  // mvi has no ry operand, so its ry field is not range-checked
  assign in_illegal = (in_op > OpXor) || !in_range(in_rx) ||
                      ((in_op != OpMvi) && !in_range(in_ry));

  logic [2:0]        ir_op;
  logic [SEL_W-1:0]  ir_rx, ir_ry;
  logic [DATA_W-1:0] rx_val, ry_val;
  assign ir_op  = ir_q[IrW-1 -: 3];
  assign ir_rx  = ir_q[IrW-4 -: SEL_W];
  assign ir_ry  = ir_q[SEL_W-1:0];
  assign rx_val = in_range(ir_rx) ? regs_q[ir_rx] : '0;
  assign ry_val = in_range(ir_ry) ? regs_q[ir_ry] : '0;

  always_comb begin
    alu_sum = '0;
    case (ir_op)
      OpAdd:   alu_sum = {1'b0, a_q} + {1'b0, ry_val};
      OpSub:   alu_sum = {1'b0, a_q} + {1'b0, ~ry_val} + {{DATA_W{1'b0}}, 1'b1};
      OpXor:   alu_sum = {1'b0, a_q ^ ry_val};
      default: alu_sum = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    a_d         = a_q;
    g_d         = g_q;
    carry_d     = carry_q;
    fz_d        = fz_q;
    fc_d        = fc_q;
    err_d       = err_q;
    bus         = '0;
    wr_en       = 1'b0;
    instr_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_d  = instr[DATA_W-1 -: IrW];
          err_d = in_illegal;
          if (in_illegal)          state_d = StDone;
          else if (in_op == OpMvi) state_d = StImm;
          else                     state_d = StT1;
        end
      end
      StImm: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          bus     = instr;
          wr_en   = 1'b1;
          state_d = StDone;
        end
      end
      StT1: begin
        if (ir_op == OpMv) begin
          bus     = ry_val;
          wr_en   = 1'b1;
          state_d = StDone;
        end else begin
          bus     = rx_val;
          a_d     = bus;
          state_d = StT2;
        end
      end
      StT2: begin
        bus     = ry_val;
        g_d     = alu_sum[DATA_W-1:0];
        carry_d = alu_sum[DATA_W];
        state_d = StT3;
      end
      StT3: begin
        bus     = g_q;
        wr_en   = 1'b1;
        fz_d    = (g_q == '0);
        fc_d    = carry_q;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[ir_rx] = bus;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      carry_q <= 1'b0;
      fz_q    <= 1'b0;
      fc_q    <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      g_q     <= g_d;
      carry_q <= carry_d;
      fz_q    <= fz_d;
      fc_q    <= fc_d;
      err_q   <= err_d;
      regs_q  <= regs_d;
    end
  end

  assign done    = (state_q == StDone);
  assign err     = done && err_q;
  assign flag_z  = fz_q;
  assign flag_c  = fc_q;
  assign rd_data = in_range(rd_sel) ? regs_q[rd_sel] : '0;
  assign bus_dbg = bus;

endmodule

// File: tb/tb_bus_datapath.sv
// Directed self-checking bench for bus_datapath: an 8-register instance for the main
// sequences and a 6-register instance for out-of-range register fields.
module tb_bus_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid, instr_ready, done, err, flag_z, flag_c;
  logic [15:0] instr, rd_data, bus_dbg;
  logic [2:0]  rd_sel;

  logic        instr_valid6, instr_ready6, done6, err6, flag_z6, flag_c6;
  logic [15:0] instr6, rd_data6, bus_dbg6;
  logic [2:0]  rd_sel6;

  int          vec_cnt  = 0;
  int          miss_cnt = 0;
  int          lat;
  logic [15:0] bus_hist [16];

  always #5 clk = ~clk;

  bus_datapath #(.DATA_W(16), .NUM_REGS(8)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .done(done), .err(err), .flag_z(flag_z), .flag_c(flag_c),
    .rd_sel(rd_sel), .rd_data(rd_data), .bus_dbg(bus_dbg)
  );

  bus_datapath #(.DATA_W(16), .NUM_REGS(6)) dut6 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid6), .instr_ready(instr_ready6),
    .instr(instr6), .done(done6), .err(err6), .flag_z(flag_z6), .flag_c(flag_c6),
    .rd_sel(rd_sel6), .rd_data(rd_data6), .bus_dbg(bus_dbg6)
  );

  function automatic logic [15:0] mk(input int op, input int rx, input int ry);
    return {op[2:0], rx[2:0], ry[2:0], 7'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input int idx, input logic [15:0] exp);
    rd_sel = idx[2:0];
    #1;
    chk($sformatf("R%0d", idx), {16'h0, rd_data}, {16'h0, exp});
  endtask

  task automatic chk_flags(input string tag, input logic z, input logic c);
    chk({tag, " flag_z"}, {31'h0, flag_z}, {31'h0, z});
    chk({tag, " flag_c"}, {31'h0, flag_c}, {31'h0, c});
  endtask

  task automatic accept(input logic [15:0] w);
    @(negedge clk);
    instr       = w;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  // Count cycles from acceptance until done, logging bus_dbg each cycle
  task automatic wait_done(output int l);
    l = 1;
    while (1) begin
      bus_hist[l] = bus_dbg;
      if (done === 1'b1 || l >= 12) break;
      @(negedge clk);
      l++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] w, input int exp_lat,
                        input logic exp_err);
    accept(w);
    wait_done(lat);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " err"}, {31'h0, err}, {31'h0, exp_err});
  endtask

  task automatic run_mvi(input int rx, input logic [15:0] imm, input int gap);
    accept(mk(1, rx, 0));
    for (int i = 0; i < gap; i++) begin
      chk("mvi wait done", {31'h0, done}, 32'h0);
      @(negedge clk);
    end
    chk("mvi imm ready", {31'h0, instr_ready}, 32'h1);
    instr       = imm;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("mvi done", {31'h0, done}, 32'h1);
    chk("mvi err", {31'h0, err}, 32'h0);
  endtask

  initial begin
    rst          = 1'b0;
    instr_valid  = 1'b0;
    instr        = '0;
    rd_sel       = '0;
    instr_valid6 = 1'b0;
    instr6       = '0;
    rd_sel6      = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_reg(3, 16'h0000);
    chk("reset done", {31'h0, done}, 32'h0);
    chk("reset bus", {16'h0, bus_dbg}, 32'h0);
    chk_flags("reset", 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready after reset", {31'h0, instr_ready}, 32'h1);

    // mvi with a stalled immediate, then a back-to-back immediate
    run_mvi(1, 16'h00FF, 3);
    run_mvi(2, 16'hFF01, 0);
    chk_reg(1, 16'h00FF);
    chk_reg(2, 16'hFF01);

    // add R1,R2 while a stray word is offered mid-instruction
    accept(mk(2, 1, 2));
    instr       = mk(7, 0, 0);
    instr_valid = 1'b1;
    chk("busy ready", {31'h0, instr_ready}, 32'h0);
    wait_done(lat);
    instr_valid = 1'b0;
    chk("add latency", lat, 4);
    chk("add err", {31'h0, err}, 32'h0);
    chk("add bus T1", {16'h0, bus_hist[1]}, 32'h00FF);
    chk("add bus T2", {16'h0, bus_hist[2]}, 32'hFF01);
    chk("add bus T3", {16'h0, bus_hist[3]}, 32'h0000);
    chk_reg(1, 16'h0000);
    chk_flags("add", 1'b1, 1'b1);

    run_op("add R2,R2", mk(2, 2, 2), 4, 1'b0);
    chk_reg(2, 16'hFE02);
    chk_flags("add R2,R2", 1'b0, 1'b1);

    run_mvi(3, 16'h0001, 0);
    run_mvi(4, 16'h0002, 0);
    run_op("sub", mk(3, 3, 4), 4, 1'b0);
    chk_reg(3, 16'hFFFF);
    chk_flags("sub", 1'b0, 1'b0);
    run_op("xor", mk(4, 3, 3), 4, 1'b0);
    chk_reg(3, 16'h0000);
    chk_flags("xor", 1'b1, 1'b0);

    run_mvi(1, 16'h1234, 0);
    chk_flags("mvi keeps", 1'b1, 1'b0);
    run_op("mv", mk(0, 5, 1), 2, 1'b0);
    chk_reg(5, 16'h1234);
    chk_flags("mv keeps", 1'b1, 1'b0);

    // Illegal opcodes leave all state alone
    run_op("op111", mk(7, 1, 2), 1, 1'b1);
    run_op("op101", mk(5, 5, 1), 1, 1'b1);
    chk_reg(1, 16'h1234);
    chk_reg(2, 16'hFE02);
    chk_reg(4, 16'h0002);
    chk_reg(5, 16'h1234);
    chk_flags("illegal keeps", 1'b1, 1'b0);

    // Six-register instance: rx=7 is out of range, rx=1 is fine
    @(negedge clk);
    instr6       = mk(0, 7, 0);
    instr_valid6 = 1'b1;
    @(negedge clk);
    instr_valid6 = 1'b0;
    chk("n6 rx7 done", {31'h0, done6}, 32'h1);
    chk("n6 rx7 err", {31'h0, err6}, 32'h1);
    @(negedge clk);
    instr6       = mk(0, 1, 0);
    instr_valid6 = 1'b1;
    @(negedge clk);
    instr_valid6 = 1'b0;
    chk("n6 mv T1 done", {31'h0, done6}, 32'h0);
    @(negedge clk);
    chk("n6 mv done", {31'h0, done6}, 32'h1);
    chk("n6 mv err", {31'h0, err6}, 32'h0);
    rd_sel6 = 3'd7;
    #1;
    chk("n6 rd oob", {16'h0, rd_data6}, 32'h0);

    // Reset during T2 of an add
    accept(mk(2, 5, 4));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst T2 done", {31'h0, done}, 32'h0);
    chk("rst T2 idle", {31'h0, instr_ready}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst T2 done after", {31'h0, done}, 32'h0);
    for (int i = 0; i < 8; i++) chk_reg(i, 16'h0000);
    chk_flags("rst T2", 1'b0, 1'b0);

    // Reset in IMM with the immediate being offered at the same edge
    accept(mk(1, 6, 0));
    rst         = 1'b0;
    instr       = 16'hBEEF;
    instr_valid = 1'b1;
    @(negedge clk);
    rst         = 1'b1;
    instr_valid = 1'b0;
    chk("rst IMM done", {31'h0, done}, 32'h0);
    chk("rst IMM idle", {31'h0, instr_ready}, 32'h1);
    chk_reg(6, 16'h0000);
    @(negedge clk);
    chk("rst IMM done after", {31'h0, done}, 32'h0);

    run_mvi(6, 16'h0A0A, 0);
    chk_reg(6, 16'h0A0A);
    run_op("mv after rst", mk(0, 0, 6), 2, 1'b0);
    chk_reg(0, 16'h0A0A);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/bus_datapath.md
BUS_DATAPATH -- requirements
Module: bus_datapath

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_W, 16, data/bus/register/instruction width.
- NUM_REGS, 8, general registers R0..R(NUM_REGS-1).
- localparam SEL_W = clog2(NUM_REGS); DATA_W >= 3+2*SEL_W required.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-low reset.
- instr_valid  in  1  instruction word offered.
- instr_ready  out  1  block accepts a word this cycle.
- instr  in  DATA_W  instruction word or mvi immediate.
- done  out  1  one-cycle pulse: instruction retired.
- err  out  1  one-cycle pulse with done: illegal instruction.
- flag_z  out  1  last ALU result was zero.
- flag_c  out  1  carry out of last add; borrow-free (no borrow) of last sub.
- rd_sel  in  SEL_W  debug register read select.
- rd_data  out  DATA_W  combinational R[rd_sel]; 0 if rd_sel >= NUM_REGS.
- bus_dbg  out  DATA_W  current internal bus value.

Function
REQ-003 The internal bus SHALL be a mux with at most one selected source per cycle (R[x], instr, G); it SHALL be 0 when no source is selected; no tri-states.
REQ-004 Instruction fields: op = instr[DATA_W-1 -: 3], rx = next SEL_W bits, ry = next SEL_W bits; remaining bits ignored.
REQ-005 Opcodes:
- 000 mv: rx <- ry.
- 001 mvi: rx <- next word.
- 010 add: rx <- rx+ry.
- 011 sub: rx <- rx-ry.
- 100 xor: rx <- rx^ry.
- 101..111: illegal.
REQ-006 FSM states SHALL be IDLE, IMM, T1, T2, T3, DONE; instr_ready SHALL be 1 only in IDLE and IMM.
REQ-007 IDLE: on instr_valid&&instr_ready, the block SHALL capture instr into IR and go to IMM (mvi), DONE with err (illegal, or rx/ry >= NUM_REGS), or T1 (otherwise); with no handshake it SHALL stay in IDLE.
REQ-008 mv: T1 SHALL drive bus=R[ry] and write R[rx], then go to DONE.
REQ-009 mvi: IMM SHALL wait indefinitely for instr_valid; on handshake it SHALL drive bus=instr, write R[rx], and go to DONE.
REQ-010 ALU ops:
- T1: bus=R[rx], A<=bus.
- T2: bus=R[ry], G<=A op bus.
- T3: bus=G, R[rx]<=G, flags updated.
- Then DONE.
REQ-011 DONE SHALL assert done=1 (and err if flagged) for exactly one cycle, then go to IDLE.
REQ-012 Latency from the accepting edge to the done cycle: mv 2 cycles; ALU ops 4 cycles; illegal 1 cycle; mvi 1 cycle after the immediate handshake.
REQ-013 Arithmetic SHALL be modulo 2^DATA_W.
- add: flag_c = carry out of bit DATA_W-1.
- sub: computed as A+~B+1; flag_c = carry out (1 means no borrow).
- xor: flag_c = 0.
- flag_z = (G == 0).
- mv, mvi and illegal SHALL NOT change the flags.
REQ-014 rx == ry SHALL be legal; e.g. add R2,R2 doubles R2, and sub R2,R2 gives 0 with flag_z=1, flag_c=1.
REQ-015 Illegal instructions SHALL NOT modify registers, A, G or flags.
REQ-016 Inputs arriving outside IDLE/IMM SHALL be ignored (not accepted).

Reset
REQ-017 While rst=0 at a clock edge:
- state <= IDLE.
- All R, A, G, IR <= 0.
- done, err, flag_z, flag_c <= 0.
REQ-018 Reset in any state, including mid-instruction or IMM, SHALL abort the instruction with no done and no partial register write at that edge.
REQ-019 During and after reset, before the first instruction, rd_data SHALL read 0 and instr_ready SHALL be 1 on the first cycle after rst returns to 1.

Verification
REQ-020 After reset, mvi R1 with immediate 0x00FF, then mvi R2 with 0xFF01 -> done pulses; R1=0x00FF, R2=0xFF01.
REQ-021 add R1,R2 (from REQ-020 values) -> done exactly 4 cycles after acceptance; R1=0x0000, flag_z=1, flag_c=1; bus_dbg sequence 0x00FF, 0xFF01, 0x0000.
REQ-022 Set R3=0x0001, R4=0x0002; sub R3,R4 -> R3=0xFFFF, flag_c=0, flag_z=0; then xor R3,R3 -> R3=0, flag_z=1, flag_c=0.
REQ-023 mv R5,R1 with R1=0x1234 -> R5=0x1234, done 2 cycles after acceptance, flags unchanged.
REQ-024 Opcode 111 -> done and err in the cycle after acceptance; all registers unchanged. Separately, a parametrisation with NUM_REGS=6 and rx=7 -> err.
REQ-025 Assert rst=0 in T2 of an add and in IMM of an mvi -> no done; all registers 0; state IDLE; a following instruction completes normally.
